line_window_ctrl: RTL

- Parametrised successor of the fixed 512-pixel, 3x3 line-buffer controller.
- Buffers a raster pixel stream into KSIZE+1 internal line buffers and emits one KSIZE x KSIZE window per accepted read column to the convolution stage.
- Adds upstream and downstream ready handshakes, line-occupancy flow control, a registered window output and a per-line interrupt.

---
 rtl/line_window_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/line_window_ctrl.sv
// Raster line buffer with KSIZE+1 lines that emits one KSIZE x KSIZE window per read column.
// Optional: define LINE_WINDOW_EDGE_ZERO_EN to zero columns past the right edge instead of wrapping.
module line_window_ctrl #(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W     = 8,
  parameter int KSIZE     = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [PIX_W-1:0]             i_pixel_data,
  input  logic                         i_pixel_data_valid,
  output logic                         o_in_ready,
  output logic [KSIZE*KSIZE*PIX_W-1:0] o_pixel_data,
  output logic                         o_pixel_data_valid,
  input  logic                         i_ready,
  output logic                         o_intr
);

  localparam int NB = KSIZE + 1;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int BW = $clog2(NB);
  localparam int LW = $clog2(KSIZE + 2);
  localparam int DW = KSIZE * KSIZE * PIX_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [BW-1:0] BUF_LAST = BW'(NB - 1);
  localparam logic [LW-1:0] LF_MAX   = LW'(NB);
  localparam logic [LW-1:0] LF_WIN   = LW'(KSIZE);
  localparam logic [CW:0]   COL_N    = (CW+1)'(IMG_WIDTH);
  localparam logic [BW:0]   BUF_N    = (BW+1)'(NB);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [PIX_W-1:0] mem_q [NB][IMG_WIDTH];

  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [BW-1:0] wr_buf_q, wr_buf_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic [BW-1:0] rd_base_q, rd_base_d;
  logic [LW-1:0] lines_full_q, lines_full_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] win_w;

  logic wr_acc;
  logic wr_wrap;
  logic step;
  logic retire;

  assign o_in_ready         = lines_full_q < LF_MAX;
  assign o_pixel_data       = data_q;
  assign o_pixel_data_valid = valid_q;
  assign o_intr             = retire;

  assign wr_acc  = i_pixel_data_valid & o_in_ready;
  assign wr_wrap = wr_acc & (wr_col_q == COL_LAST);

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem_q[wr_buf_q][wr_col_q] <= i_pixel_data;
    end
  end

  always_comb begin
    wr_col_d = wr_col_q;
    wr_buf_d = wr_buf_q;
    if (wr_acc) begin
      wr_col_d = wr_col_q + 1'b1;
      if (wr_wrap) begin
        wr_col_d = '0;
        wr_buf_d = (wr_buf_q == BUF_LAST) ? '0 : wr_buf_q + 1'b1;
      end
    end
  end

  // Window taps: row r from buffer rd_base+r, column offset k from rd_col+k.
  always_comb begin
    logic [BW:0] bsum;
    logic [CW:0] csum;
    win_w = '0;
    bsum  = '0;
    csum  = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int k = 0; k < KSIZE; k++) begin
        bsum = {1'b0, rd_base_q} + (BW+1)'(r);
        if (bsum >= BUF_N) begin
          bsum = bsum - BUF_N;
        end
        csum = {1'b0, rd_col_q} + (CW+1)'(k);
`ifdef LINE_WINDOW_EDGE_ZERO_EN
        if (csum < COL_N) begin
          win_w[((r*KSIZE)+(KSIZE-1-k))*PIX_W +: PIX_W] =
            mem_q[bsum[BW-1:0]][csum[CW-1:0]];
        end
`else
        if (csum >= COL_N) begin
          csum = csum - COL_N;
        end
        win_w[((r*KSIZE)+(KSIZE-1-k))*PIX_W +: PIX_W] =
          mem_q[bsum[BW-1:0]][csum[CW-1:0]];
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_col_d  = rd_col_q;
    rd_base_d = rd_base_q;
    data_d    = data_q;
    valid_d   = valid_q;
    step      = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd_col_d = '0;
        if (lines_full_q >= LF_WIN) begin
          state_d = READ;
        end
      end
      READ: begin
        if (!valid_q || i_ready) begin
          step     = 1'b1;
          data_d   = win_w;
          rd_col_d = rd_col_q + 1'b1;
          if (rd_col_q == COL_LAST) begin
            rd_col_d = '0;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (valid_q && i_ready) begin
          retire    = 1'b1;
          state_d   = IDLE;
          rd_base_d = (rd_base_q == BUF_LAST) ? '0 : rd_base_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (step) begin
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // A finished write line and a retired read line cancel out.
  always_comb begin
    lines_full_d = lines_full_q;
    unique case ({wr_wrap, retire})
      2'b10:   lines_full_d = lines_full_q + 1'b1;
      2'b01:   lines_full_d = lines_full_q - 1'b1;
      default: lines_full_d = lines_full_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      wr_col_q     <= '0;
      wr_buf_q     <= '0;
      rd_col_q     <= '0;
      rd_base_q    <= '0;
      lines_full_q <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_col_q     <= wr_col_d;
      wr_buf_q     <= wr_buf_d;
      rd_col_q     <= rd_col_d;
      rd_base_q    <= rd_base_d;
      lines_full_q <= lines_full_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
    end
  end

endmodule
